// File: rtl/countdown_timer_16bit_pkg.sv
// Shared definitions for the 16-bit countdown timer: state encoding,
// counter width and the ripple-free adder helper used by the decrementer.
package countdown_timer_16bit_pkg;

    localparam int CT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_EXPIRE = 2'b10
    } state_e;

    // Any unused encoding recovers to IDLE.
    localparam state_e ST_DEFAULT = ST_IDLE;

    // 16-bit adder returning {carry_out, sum}.
    function automatic logic [16:0] adder_16bit(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/countdown_timer_16bit_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
interface countdown_timer_16bit_if;

    // All master outputs are level signals sampled on every rising clk edge;
    // there is no valid/ready pairing: a command is taken on the edge it is seen,
    // and status outputs are registered (valid from the edge after the cause).
    logic                                          load;
    logic [countdown_timer_16bit_pkg::CT_WIDTH-1:0] load_val;
    logic                                          start;
    logic                                          stop;
    logic                                          tick;
    logic                                          auto_reload;
    logic [countdown_timer_16bit_pkg::CT_WIDTH-1:0] count;
    logic                                          busy;
    logic                                          done;
    logic                                          underflow;
    countdown_timer_16bit_pkg::state_e             state;

    modport master (
        output load, load_val, start, stop, tick, auto_reload,
        input  count, busy, done, underflow, state
    );

    modport slave (
        input  load, load_val, start, stop, tick, auto_reload,
        output count, busy, done, underflow, state
    );

endinterface

// File: rtl/decrement_16bit.sv
// Combinational 16-bit decrementer: A + 0xFFFF, borrow flags A == 0.
module decrement_16bit
    import countdown_timer_16bit_pkg::*;
(
    input  logic [15:0] A,
    output logic [15:0] decA,
    output logic        borrow
);

    logic [16:0] sum;

    assign sum    = adder_16bit(A, 16'hFFFF);
    assign decA   = sum[15:0];
    // Adding all-ones carries out for every A except zero.
    assign borrow = ~sum[16];

endmodule

// File: rtl/countdown_timer_16bit.sv
// Interval timer / event counter: loads a start value, decrements on tick,
// strobes done for one cycle on expiry, optionally reloads and restarts.
module countdown_timer_16bit
    import countdown_timer_16bit_pkg::*;
#(
    parameter int WIDTH = CT_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst_n,
    countdown_timer_16bit_if.slave  bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               underflow_q, underflow_d;

    logic [WIDTH-1:0]   count_dec;
    logic               dec_borrow;
    logic [WIDTH-1:0]   eff_count;

    decrement_16bit u_dec (
        .A      (count_q),
        .decA   (count_dec),
        .borrow (dec_borrow)
    );

    // A simultaneous load and start in IDLE starts from the freshly loaded value.
    assign eff_count = bus.load ? bus.load_val : count_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = underflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    count_d     = bus.load_val;
                    reload_d    = bus.load_val;
                    underflow_d = 1'b0;
                end
                if (bus.start) begin
                    if (eff_count != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d     = ST_EXPIRE;
                        underflow_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // Loading while running only retargets the next reload.
                if (bus.load) begin
                    reload_d = bus.load_val;
                end
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.tick) begin
                    count_d = count_dec;
                    if (count_q == WIDTH'(1)) begin
                        state_d = ST_EXPIRE;
                    end
                end
            end

            ST_EXPIRE: begin
                if (bus.load) begin
                    reload_d = bus.load_val;
                end
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                    state_d = ST_RUN;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_DEFAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
        end
    end

    // RUN is never entered with a zero count, so a decrement never borrows.
    assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == ST_RUN) && bus.tick && !bus.stop && dec_borrow));

    assign bus.count     = count_q;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_EXPIRE);
    assign bus.done      = (state_q == ST_EXPIRE);
    assign bus.underflow = underflow_q;
    assign bus.state     = state_q;

endmodule
